// File: rtl/ultrasonic_scan_ctrl_pkg.sv
// Shared types and 50 MHz default timing constants for the ultrasonic scanner.
// Also used by the downstream distance converter.
package ultrasonic_scan_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TRIG,
        S_WAIT,
        S_MEAS,
        S_DONE,
        S_HOLD
    } state_t;

    localparam int DEF_TRIG_CYC    = 500;
    localparam int DEF_TIMEOUT_CYC = 1_000_000;
    localparam int DEF_HOLDOFF_CYC = 3_000_000;
    localparam int DEF_THRESH_CYC  = 29_000;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ultrasonic_scan_ctrl_echo_sync.sv
// Per-bit 2-FF synchronizer for the raw echo pins.
// Rise/fall pulses come from the synchronized value, so both edges see equal latency.
module echo_sync #(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] d,
    output logic [N-1:0] rise,
    output logic [N-1:0] fall
);

    logic [N-1:0] s1;
    logic [N-1:0] s2;
    logic [N-1:0] s3;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1 <= '0;
            s2 <= '0;
            s3 <= '0;
        end else begin
            s1 <= d;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;
    assign fall = ~s2 & s3;

endmodule

// File: rtl/ultrasonic_scan_ctrl.sv
// Round-robin HC-SR04 scanner: trigger, time echo, timeout, publish width/presence.
// One shared counter serves trigger, rise wait, echo timing and holdoff.
module ultrasonic_scan_ctrl
    import ultrasonic_scan_ctrl_pkg::*;
#(
    parameter int N_SENS      = 2,
    parameter int W           = 20,
    parameter int TRIG_CYC    = DEF_TRIG_CYC,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    parameter int HOLDOFF_CYC = DEF_HOLDOFF_CYC,
    parameter int THRESH_CYC  = DEF_THRESH_CYC,
    localparam int SW = (N_SENS > 1) ? $clog2(N_SENS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [N_SENS-1:0] echo,
    output logic [N_SENS-1:0] trig,
    output logic [W-1:0]      width,
    output logic [SW-1:0]     width_sel,
    output logic              width_valid,
    output logic              timeout,
    output logic [N_SENS-1:0] present,
    output logic              busy
);

    localparam int CW = max_int(max_int(W, $clog2(HOLDOFF_CYC + 1)),
                                $clog2(TRIG_CYC + 1));

    localparam logic [CW-1:0] TRIG_LAST = CW'(TRIG_CYC - 1);
    localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT_CYC - 1);
    localparam logic [CW-1:0] TO_FULL   = CW'(TIMEOUT_CYC);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLDOFF_CYC - 1);
    localparam logic [CW-1:0] THRESH    = CW'(THRESH_CYC);

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [SW-1:0] sel, sel_n;
    logic          meas_to, meas_to_n;
    logic [N_SENS-1:0] rise, fall;
    logic          rise_s, fall_s;

    echo_sync #(.N(N_SENS)) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (echo),
        .rise (rise),
        .fall (fall)
    );

    assign rise_s = rise[sel];
    assign fall_s = fall[sel];
    assign busy   = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            cnt     <= '0;
            sel     <= '0;
            meas_to <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            sel     <= sel_n;
            meas_to <= meas_to_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        sel_n     = sel;
        meas_to_n = meas_to;
        unique case (state)
            S_IDLE: begin
                cnt_n = '0;
                if (enable) state_n = S_TRIG;
            end
            S_TRIG: begin
                if (cnt == TRIG_LAST) begin
                    cnt_n   = '0;
                    state_n = S_WAIT;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            // A rise on the terminal-count cycle still starts a measurement.
            S_WAIT: begin
                if (rise_s) begin
                    cnt_n   = CW'(1);
                    state_n = S_MEAS;
                end else if (cnt == TO_LAST) begin
                    cnt_n     = '0;
                    meas_to_n = 1'b1;
                    state_n   = S_DONE;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            S_MEAS: begin
                if (fall_s) begin
                    meas_to_n = 1'b0;
                    state_n   = S_DONE;
                end else if (cnt == TO_FULL) begin
                    meas_to_n = 1'b1;
                    state_n   = S_DONE;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            S_DONE: begin
                cnt_n   = '0;
                state_n = S_HOLD;
            end
            S_HOLD: begin
                if (cnt == HOLD_LAST) begin
                    cnt_n   = '0;
                    sel_n   = (sel == SW'(N_SENS - 1)) ? '0 : sel + SW'(1);
                    state_n = enable ? S_TRIG : S_IDLE;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // In DONE the counter still holds the finished width (0 on a rise timeout).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            trig        <= '0;
            width       <= '0;
            width_sel   <= '0;
            width_valid <= 1'b0;
            timeout     <= 1'b0;
            present     <= '0;
        end else begin
            trig        <= (state == S_TRIG) ? (N_SENS'(1) << sel) : '0;
            width_valid <= (state == S_DONE);
            if (state == S_DONE) begin
                width        <= cnt[W-1:0];
                width_sel    <= sel;
                timeout      <= meas_to;
                present[sel] <= !meas_to && (cnt < THRESH);
            end
        end
    end

endmodule

// File: tb/tb_ultrasonic_scan_ctrl.sv
// Scoreboard bench for ultrasonic_scan_ctrl with shortened timeout/holdoff.
// Expected strobes are queued at stimulus time and popped by the monitor.
module tb_ultrasonic_scan_ctrl;

    localparam int N    = 2;
    localparam int W    = 20;
    localparam int TRIG = 500;
    localparam int TO   = 6000;
    localparam int HOLD = 1000;
    localparam int THR  = 2900;
    localparam int BND  = 20000;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         enable;
    logic [N-1:0] echo;
    logic [N-1:0] trig;
    logic [W-1:0] width;
    logic [0:0]   width_sel;
    logic         width_valid;
    logic         timeout;
    logic [N-1:0] present;
    logic         busy;

    typedef struct {
        int sel;
        int width;
        int to;
        int pres;
        int cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   pres_m = 0;

    ultrasonic_scan_ctrl #(
        .N_SENS     (N),
        .W          (W),
        .TRIG_CYC   (TRIG),
        .TIMEOUT_CYC(TO),
        .HOLDOFF_CYC(HOLD),
        .THRESH_CYC (THR)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .echo       (echo),
        .trig       (trig),
        .width      (width),
        .width_sel  (width_sel),
        .width_valid(width_valid),
        .timeout    (timeout),
        .present    (present),
        .busy       (busy)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic void push(input int s, input int w, input int t,
                                 input int c);
        exp_t e;
        if (t == 0 && w < THR) pres_m = pres_m | (1 << s);
        else pres_m = pres_m & ~(1 << s);
        e.sel   = s;
        e.width = w;
        e.to    = t;
        e.pres  = pres_m;
        e.cyc   = c;
        sb.push_back(e);
    endfunction

    always @(negedge clk) begin
        if (rst_n === 1'b1 && width_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("extra_strobe", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                check("width", width, mon_e.width);
                check("width_sel", width_sel, mon_e.sel);
                check("timeout", timeout, mon_e.to);
                check("present", present, mon_e.pres);
                if (mon_e.cyc >= 0) check("strobe_cyc", cyc, mon_e.cyc);
            end
        end
    end

    task automatic wait_trig(input int s, output int lat, output int fall);
        int hi;
        lat = 0;
        hi  = 0;
        while (trig[s] !== 1'b1 && lat < BND) begin
            @(negedge clk);
            lat++;
        end
        if (trig[s] !== 1'b1) begin
            $display("FAIL trig_rise: sensor %0d never triggered", s);
            errors++;
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $fatal(1);
        end
        check("trig_other", trig & ~(N'(1) << s), 0);
        while (trig[s] === 1'b1 && hi < BND) begin
            @(negedge clk);
            hi++;
        end
        check("trig_len", hi, TRIG);
        fall = cyc;
    endtask

    task automatic pulse(input int s, input int dly, input int len);
        repeat (dly) @(negedge clk);
        echo[s] = 1'b1;
        repeat (len) @(negedge clk);
        echo[s] = 1'b0;
    endtask

    task automatic wait_sb();
        int n;
        n = 0;
        while (sb.size() > 0 && n < BND) begin
            @(negedge clk);
            n++;
        end
        check("sb_drain", sb.size(), 0);
    endtask

    initial begin
        #(150_000 * 20);
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks);
        $fatal(1);
    end

    initial begin
        int lat;
        int fall;
        int n;
        rst_n  = 1'b0;
        enable = 1'b1;
        echo   = '0;
        repeat (5) @(negedge clk);
        check("rst_trig", trig, 0);
        check("rst_width", width, 0);
        check("rst_sel", width_sel, 0);
        check("rst_valid", width_valid, 0);
        check("rst_timeout", timeout, 0);
        check("rst_present", present, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;

        wait_trig(0, lat, fall);
        check("trig_lat", lat, 2);
        push(0, 1750, 0, -1);
        pulse(0, 1250, 1750);

        wait_trig(1, lat, fall);
        push(1, 5000, 0, -1);
        pulse(0, 20, 300);
        pulse(1, 100, 5000);

        wait_trig(0, lat, fall);
        push(0, 0, 1, fall + TO);

        wait_trig(1, lat, fall);
        push(1, THR - 1, 0, -1);
        pulse(1, 40, THR - 1);

        wait_trig(0, lat, fall);
        push(0, THR, 0, -1);
        pulse(0, 40, THR);

        wait_trig(1, lat, fall);
        push(1, TO, 1, -1);
        pulse(1, 10, TO + 200);
        echo[0] = 1'b1;

        wait_trig(0, lat, fall);
        push(0, 0, 1, fall + TO);

        wait_trig(1, lat, fall);
        push(1, 0, 1, fall + TO);

        wait_trig(0, lat, fall);
        push(0, 1000, 0, -1);
        echo[0] = 1'b0;
        pulse(0, 50, 1000);

        wait_trig(1, lat, fall);
        push(1, 800, 0, -1);
        repeat (100) @(negedge clk);
        echo[1] = 1'b1;
        repeat (100) @(negedge clk);
        enable = 1'b0;
        repeat (700) @(negedge clk);
        echo[1] = 1'b0;
        wait_sb();
        check("busy_hold", busy, 1);
        repeat (HOLD + 5) @(negedge clk);
        check("busy_idle", busy, 0);
        n = 0;
        repeat (2000) begin
            @(negedge clk);
            if (trig !== '0 || busy !== 1'b0) n++;
        end
        check("idle_quiet", n, 0);

        enable = 1'b1;
        wait_trig(0, lat, fall);
        pulse(0, 10, 0);
        echo[0] = 1'b1;
        repeat (200) @(negedge clk);
        rst_n  = 1'b0;
        enable = 1'b0;
        @(negedge clk);
        check("mrst_busy", busy, 0);
        check("mrst_present", present, 0);
        check("mrst_trig", trig, 0);
        check("mrst_width", width, 0);
        check("mrst_valid", width_valid, 0);
        echo  = '0;
        rst_n = 1'b1;
        repeat (50) @(negedge clk);
        check("post_busy", busy, 0);
        check("sb_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
